wave_channel: RTL and testbench

- Game Boy channel 3 (wave channel); sibling of the pulse channels, sitting directly upstream of the mixer.
- Plays a 32-entry, 4-bit user wave table at a programmable rate, with a length counter and a coarse volume shift.
- Produces one 4-bit digital sample per clock for the mixer, plus an active flag for status readback.
- Runs on the 4194304 Hz base clock; the 256 Hz frame-sequencer tick arrives as a one-cycle enable.

---
 rtl/wave_channel.sv | 98 +++++++++
 tb/tb_wave_channel.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wave_channel.sv
// Wave channel: 32-nibble user wave table played at (2048-freq)*2 clocks per
// step, with a 256 Hz length counter, DAC gate and 2-bit volume shift.
module wave_channel #(
  parameter int FREQ_W = 11,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk256,
  input  logic              dac_en,
  input  logic              len_wr,
  input  logic [7:0]        len_load,
  input  logic [1:0]        vol_code,
  input  logic [FREQ_W-1:0] freq,
  input  logic              len_enable,
  input  logic              trigger,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [3:0]        sample,
  output logic              active
);
  localparam int TW = FREQ_W + 1;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(256);

  logic [15:0][7:0] ram;
  logic [4:0]       pos;
  logic [3:0]       sbuf;
  logic [TW-1:0]    timer;
  logic [LEN_W-1:0] len;
  logic             act;

  // (2^FREQ_W - freq)*2 - 1 == all-ones minus 2*freq == bitwise inverse of {freq,0}
  logic [TW-1:0] reload;
  assign reload = ~{freq, 1'b0};

  logic [4:0] pos_nx;
  logic [7:0] byte_nx;
  logic [3:0] nib_nx;
  assign pos_nx  = pos + 5'd1;
  assign byte_nx = ram[pos_nx[4:1]];
  assign nib_nx  = pos_nx[0] ? byte_nx[3:0] : byte_nx[7:4];

  logic len_tick, len_expire;
  assign len_tick   = clk256 & len_enable & (len != '0);
  assign len_expire = len_tick & ~len_wr & (len == LEN_W'(1));

  // Fetch reads the pre-edge RAM contents, so a same-cycle write is seen next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ram <= '0;
    else if (wr_en)  ram[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      pos   <= '0;
      sbuf  <= '0;
    end else if (trigger) begin
      timer <= reload;
      pos   <= '0;
    end else if (act) begin
      if (timer == '0) begin
        timer <= reload;
        pos   <= pos_nx;
        sbuf  <= nib_nx;
      end else begin
        timer <= timer - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        len <= '0;
    else if (len_wr)                   len <= LEN_FULL - LEN_W'(len_load);
    else if (trigger && len == '0)     len <= LEN_FULL;
    else if (len_tick)                 len <= len - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) act <= 1'b0;
    else        act <= (trigger ? dac_en : act) & ~len_expire & dac_en;
  end

  always_comb begin
    sample = '0;
    if (act) begin
      case (vol_code)
        2'd1:    sample = sbuf;
        2'd2:    sample = sbuf >> 1;
        2'd3:    sample = sbuf >> 2;
        default: sample = '0;
      endcase
    end
  end

  assign active = act;
endmodule

// File: tb/tb_wave_channel.sv
// Bench for wave_channel: cycle model of the channel rules plus directed checks.
module tb_wave_channel;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        clk256 = 0, dac_en = 0, len_wr = 0, len_enable = 0, trigger = 0, wr_en = 0;
  logic [7:0]  len_load = 0, wr_data = 0;
  logic [1:0]  vol_code = 2'd1;
  logic [10:0] freq = 0;
  logic [3:0]  wr_addr = 0;
  logic [3:0]  sample;
  logic        active;

  int n_chk = 0, n_fail = 0;

  wave_channel dut (
    .clk(clk), .rst_n(rst_n), .clk256(clk256), .dac_en(dac_en), .len_wr(len_wr),
    .len_load(len_load), .vol_code(vol_code), .freq(freq), .len_enable(len_enable),
    .trigger(trigger), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sample(sample), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: countdown of cycles to the next step, position, buffered nibble, length.
  int m_rem = 0, m_pos = 0, m_buf = 0, m_len = 0;
  bit m_act = 0;
  int mram [16];

  function automatic int nib(input int p);
    int b;
    b = mram[p / 2];
    return (p % 2) ? (b & 15) : (b >> 4);
  endfunction

  task automatic model_step();
    int p;
    bit expire;
    if (!rst_n) begin
      m_rem = 0; m_pos = 0; m_buf = 0; m_len = 0; m_act = 0;
      foreach (mram[i]) mram[i] = 0;
    end else begin
      p = (2048 - int'(freq)) * 2;
      expire = 0;
      if (trigger) begin
        m_rem = p; m_pos = 0;
      end else if (m_act) begin
        m_rem--;
        if (m_rem == 0) begin
          m_pos = (m_pos + 1) % 32;
          m_buf = nib(m_pos);
          m_rem = p;
        end
      end
      if (len_wr) m_len = 256 - int'(len_load);
      else if (trigger && m_len == 0) m_len = 256;
      else if (clk256 && len_enable && m_len != 0) begin
        m_len--;
        if (m_len == 0) expire = 1;
      end
      if (trigger) m_act = dac_en;
      if (expire || !dac_en) m_act = 0;
      if (wr_en) mram[wr_addr] = int'(wr_data);
    end
  endtask

  function automatic int exp_sample();
    if (!m_act || vol_code == 0) return 0;
    return m_buf >> (int'(vol_code) - 1);
  endfunction

  always @(posedge clk) begin
    model_step();
    #1;
    chk("model_active", int'(active), int'(m_act));
    chk("model_sample", int'(sample), exp_sample());
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse256();
    clk256 = 1; cyc(1); clk256 = 0; cyc(1);
  endtask

  logic [7:0] wave [16] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                            8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};

  initial begin
    cyc(3);
    chk("reset_active", int'(active), 0);
    chk("reset_sample", int'(sample), 0);
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_addr = 4'(i); wr_data = wave[i]; cyc(1);
    end
    wr_en = 0;

    // Playback at P=16
    freq = 11'd2040; dac_en = 1; trigger = 1; cyc(1); trigger = 0;
    chk("trig_active", int'(active), 1);
    chk("trig_sample0", int'(sample), 0);
    cyc(15); chk("hold_15", int'(sample), 0);
    cyc(1);  chk("step_pos1", int'(sample), 1);
    cyc(16); chk("step_pos2", int'(sample), 2);
    cyc(16 * 12); chk("step_pos14", int'(sample), 'hE);
    vol_code = 0; #1 chk("vol0", int'(sample), 0);
    vol_code = 2; #1 chk("vol2", int'(sample), 7);
    vol_code = 3; #1 chk("vol3", int'(sample), 3);
    vol_code = 1; #1 chk("vol1", int'(sample), 'hE);
    cyc(16); chk("pos15", int'(sample), 'hF);
    cyc(16); chk("pos16", int'(sample), 'hF);
    cyc(16); chk("pos17", int'(sample), 'hE);
    cyc(16 * 14); chk("pos31", int'(sample), 0);
    cyc(16); chk("wrap_pos0", int'(sample), 0);
    cyc(16); chk("wrap_pos1", int'(sample), 1);

    // Length 254 -> 2 ticks
    len_load = 8'd254; len_wr = 1; len_enable = 1; trigger = 1; cyc(1);
    len_wr = 0; trigger = 0;
    chk("len_trig_active", int'(active), 1);
    pulse256(); chk("len_tick1", int'(active), 1);
    pulse256(); chk("len_tick2_active", int'(active), 0);
    chk("len_tick2_sample", int'(sample), 0);
    pulse256(); chk("len_tick3", int'(active), 0);

    // Counter 0: trigger with clk256 loads 256, no decrement
    trigger = 1; clk256 = 1; cyc(1); trigger = 0; clk256 = 0; cyc(1);
    chk("trig256_active", int'(active), 1);
    repeat (255) pulse256();
    chk("len256_after255", int'(active), 1);
    pulse256();
    chk("len256_expire", int'(active), 0);

    // DAC gate
    trigger = 1; cyc(1); trigger = 0;
    chk("dac_on", int'(active), 1);
    dac_en = 0; cyc(1);
    chk("dac_off", int'(active), 0);
    trigger = 1; cyc(1); trigger = 0;
    chk("dac_off_retrig", int'(active), 0);
    dac_en = 1;

    // Read-before-write on the fetched byte, P=2
    len_enable = 0; freq = 11'd2047; trigger = 1; cyc(1); trigger = 0; cyc(1);
    wr_en = 1; wr_addr = 0; wr_data = 8'h55; cyc(1); wr_en = 0;
    chk("rbw_old_nibble", int'(sample), 1);
    cyc(2); chk("rbw_pos2", int'(sample), 2);
    cyc(5); freq = 11'd2044; cyc(80);

    // Async reset mid-playback
    chk("pre_reset_active", int'(active), 1);
    #3 rst_n = 0;
    #1 chk("async_rst_active", int'(active), 0);
    chk("async_rst_sample", int'(sample), 0);
    cyc(2); rst_n = 1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      chk("post_reset_quiet", int'(sample) | (int'(active) << 4), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
